// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier for the execute stage.
// One partial-product step per clock; fixed WIDTH-cycle RUN phase, then a one-cycle DONE
// that strobes the register-file write port with the low half of the product.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         dest_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   wd_out,
  output logic [1:0]         wr_out,
  output logic               regwrite_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_shift_q, b_shift_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         dest_q, dest_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [1:0]         wr_q, wr_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // One shift-add step: add multiplicand into the upper half, keep the carry, shift right.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_shift_q[0] ? a_q : '0)};
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  // Next-state logic: operand capture, step sequencing and result write-back.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_shift_d = b_shift_q;
    acc_d     = acc_q;
    count_d   = count_q;
    dest_d    = dest_q;
    product_d = product_q;
    wr_d      = wr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d       = a;
          b_shift_d = b;
          dest_d    = dest_in;
          acc_d     = '0;
          count_d   = '0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately ignored here: no capture, no restart.
        acc_d     = acc_step;
        b_shift_d = b_shift_q >> 1;
        count_d   = count_q + CW'(1);
        if (count_q == LastStep) begin
          // Outputs only ever change on this edge (or reset).
          product_d = acc_step;
          wr_d      = dest_q;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_shift_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      dest_q    <= '0;
      product_q <= '0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_shift_q <= b_shift_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      dest_q    <= dest_d;
      product_q <= product_d;
      wr_q      <= wr_d;
    end
  end

  // Outputs decoded from registered state; writes to r0 are suppressed.
  always_comb begin
    busy         = (state_q == RUN);
    done         = (state_q == DONE);
    regwrite_out = (state_q == DONE) && (wr_q != 2'd0);
    product      = product_q;
    wd_out       = product_q[WIDTH-1:0];
    wr_out       = wr_q;
  end

endmodule
